// File: rtl/gen_window_sequencer_pkg.sv
// rtl/gen_window_sequencer_pkg.sv - shared constants for the window sequencer
// Purpose: FSM state encodings and word-size constants used by the
//          window sequencer top and its position counter.
// Ports:   none (package)
package gen_window_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/gen_window_sequencer_window_pos_counter.sv
// rtl/gen_window_sequencer_window_pos_counter.sv - 2-D raster row/col counter
// Purpose: steps a window origin column-first across a row, then to the next row.
// Ports:   clk_i, rst_i        clock, synchronous active-high reset
//          clear_i             return to (0,0)
//          advance_i           step to the next raster position
//          col_lim_i/row_lim_i last valid column/row index
//          row_o, col_o        current position
//          last_col_o          column is at its limit
//          last_pos_o          both row and column at their limits
module window_pos_counter #(
  parameter int DIM_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [DIM_W-1:0] col_lim_i,
  input  logic [DIM_W-1:0] row_lim_i,
  output logic [DIM_W-1:0] row_o,
  output logic [DIM_W-1:0] col_o,
  output logic             last_col_o,
  output logic             last_pos_o
);

  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic             last_row;

  // >= rather than == so a counter can never run past a limit
  assign last_col_o = (col_q >= col_lim_i);
  assign last_row   = (row_q >= row_lim_i);
  assign last_pos_o = last_col_o & last_row;
  assign row_o      = row_q;
  assign col_o      = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (!last_col_o) begin
        col_d = col_q + 1'b1;
      end else if (!last_row) begin
        row_d = row_q + 1'b1;
        col_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/gen_window_sequencer.sv
// rtl/gen_window_sequencer.sv - raster window origin sequencer for block-match search
// Purpose: steps a WinW x WinH window origin over a FrameW x FrameH frame and
//          emits one byte offset per position over a valid/ready handshake.
// Ports:   Clk, Rst                  clock, synchronous active-high reset
//          Start                     begin a search (accepted only in IDLE)
//          BaseAddr, FrameW, FrameH,
//          WinW, WinH                search configuration, latched on Start
//          Offset, Row, Col          current position and its byte offset
//          OffValid, OffReady        output handshake
//          Busy                      search in progress (CHECK/RUN)
//          Done                      one-cycle end-of-search pulse
//          CfgErr                    sticky bad-configuration flag
module gen_window_sequencer
  import gen_window_sequencer_pkg::*;
#(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [DIM_W-1:0]  FrameW,
  input  logic [DIM_W-1:0]  FrameH,
  input  logic [DIM_W-1:0]  WinW,
  input  logic [DIM_W-1:0]  WinH,
  output logic [ADDR_W-1:0] Offset,
  output logic [DIM_W-1:0]  Row,
  output logic [DIM_W-1:0]  Col,
  output logic              OffValid,
  input  logic              OffReady,
  output logic              Busy,
  output logic              Done,
  output logic              CfgErr
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DIM_W-1:0]  fw_q, fw_d;
  logic [DIM_W-1:0]  fh_q, fh_d;
  logic [DIM_W-1:0]  ww_q, ww_d;
  logic [DIM_W-1:0]  wh_q, wh_d;
  logic [ADDR_W-1:0] row_stride_q, row_stride_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cfg_bad;
  logic              xfer;
  logic              last_col;
  logic              last_pos;
  logic [DIM_W-1:0]  col_lim;
  logic [DIM_W-1:0]  row_lim;
  logic [ADDR_W-1:0] next_row_base;

  assign cfg_bad = (fw_q == '0) || (fh_q == '0) || (ww_q == '0) || (wh_q == '0) ||
                   (ww_q > fw_q) || (wh_q > fh_q);

  // Only meaningful once CHECK has proven the window fits inside the frame
  assign col_lim = fw_q - ww_q;
  assign row_lim = fh_q - wh_q;

  assign xfer          = (state_q == ST_RUN) && OffReady;
  assign next_row_base = row_base_q + row_stride_q;

  window_pos_counter #(
    .DIM_W(DIM_W)
  ) u_pos (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .clear_i   (state_q == ST_CHECK),
    .advance_i (xfer),
    .col_lim_i (col_lim),
    .row_lim_i (row_lim),
    .row_o     (Row),
    .col_o     (Col),
    .last_col_o(last_col),
    .last_pos_o(last_pos)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    fw_d         = fw_q;
    fh_d         = fh_q;
    ww_d         = ww_q;
    wh_d         = wh_q;
    row_stride_d = row_stride_q;
    row_base_d   = row_base_q;
    offset_d     = offset_q;
    cfg_err_d    = cfg_err_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          base_d    = BaseAddr;
          fw_d      = FrameW;
          fh_d      = FrameH;
          ww_d      = WinW;
          wh_d      = WinH;
          cfg_err_d = 1'b0;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Stride is a shift of the frame width; every later address is an add
        row_stride_d = {{(ADDR_W-DIM_W){1'b0}}, fw_q} << WORD_SHIFT;
        row_base_d   = base_q;
        offset_d     = base_q;
        if (cfg_bad) begin
          cfg_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (!last_col) begin
            offset_d = offset_q + ADDR_W'(WORD_BYTES);
          end else if (!last_pos) begin
            row_base_d = next_row_base;
            offset_d   = next_row_base;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      fw_q         <= '0;
      fh_q         <= '0;
      ww_q         <= '0;
      wh_q         <= '0;
      row_stride_q <= '0;
      row_base_q   <= '0;
      offset_q     <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      fw_q         <= fw_d;
      fh_q         <= fh_d;
      ww_q         <= ww_d;
      wh_q         <= wh_d;
      row_stride_q <= row_stride_d;
      row_base_q   <= row_base_d;
      offset_q     <= offset_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign Offset   = offset_q;
  assign OffValid = (state_q == ST_RUN);
  assign Busy     = (state_q == ST_CHECK) || (state_q == ST_RUN);
  assign Done     = (state_q == ST_DONE);
  assign CfgErr   = cfg_err_q;

endmodule
